// File: rtl/control_pkg.sv
// Shared definitions for the instruction fetch front end: FSM encoding,
// micro-address park value and instruction field layout.
package control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_DISPATCH = 2'd2,
    ST_EXECUTE  = 2'd3
  } state_e;

  localparam int unsigned UADDR_WIDTH  = 3;
  localparam logic [UADDR_WIDTH-1:0] UADDR_PARK = 3'b111;
  localparam int unsigned OPCODE_WIDTH = 4;

  // Lowest bit of the opcode field; the operand occupies everything below it.
  function automatic int unsigned opcode_lsb(input int unsigned data_width);
    return data_width - OPCODE_WIDTH;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: wrapping increment, parallel load (load has priority),
// asynchronous active-low clear. Also exposes the value it will take next.
module program_counter #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  inc_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] load_value_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_next_o
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_value_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;

endmodule

// File: rtl/instruction_fetcher.sv
// Fetches one instruction per microprogram over a req/ack memory port,
// holds it in the instruction register and paces the microsequencer.
module instruction_fetcher
  import control_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_ack,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic [OPCODE_WIDTH-1:0]      opcode,
  output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand,
  output logic                         enable_count,
  input  logic [UADDR_WIDTH-1:0]       uaddress,
  output logic                         instr_valid,
  input  logic                         pc_load,
  input  logic [ADDR_WIDTH-1:0]        pc_load_value,
  input  logic                         halt,
  output logic [ADDR_WIDTH-1:0]        pc
);

  localparam int unsigned OPC_LSB   = opcode_lsb(DATA_WIDTH);
  localparam int unsigned OPR_WIDTH = DATA_WIDTH - OPCODE_WIDTH;

  state_e                  state_q, state_d;
  logic                    mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [OPR_WIDTH-1:0]    operand_q, operand_d;
  logic                    enable_count_c;
  logic                    pc_inc_c;
  logic                    pc_load_c;
  logic                    parked_c;
  logic [ADDR_WIDTH-1:0]   pc_cur;
  logic [ADDR_WIDTH-1:0]   pc_next_c;

  assign parked_c  = (uaddress == UADDR_PARK);
  assign pc_inc_c  = (state_q == ST_FETCH) && mem_req_q && mem_ack;
  assign pc_load_c = (state_q == ST_EXECUTE) && pc_load;

  program_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pc (
    .clock       (clock),
    .reset_n     (reset_n),
    .inc_i       (pc_inc_c),
    .load_i      (pc_load_c),
    .load_value_i(pc_load_value),
    .pc_o        (pc_cur),
    .pc_next_o   (pc_next_c)
  );

  // Next state, fetch request and instruction register updates.
  always_comb begin
    state_d        = state_q;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    opcode_d       = opcode_q;
    operand_d      = operand_q;
    enable_count_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!halt) begin
          state_d    = ST_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_cur;
        end
      end
      ST_FETCH: begin
        if (mem_req_q && mem_ack) begin
          opcode_d  = mem_rdata[DATA_WIDTH-1:OPC_LSB];
          operand_d = mem_rdata[OPC_LSB-1:0];
          mem_req_d = 1'b0;
          state_d   = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        enable_count_c = 1'b1;
        state_d        = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        enable_count_c = !parked_c;
        if (parked_c) begin
          if (halt) begin
            state_d = ST_IDLE;
          end else begin
            // A branch taken on this same cycle must already steer the fetch.
            state_d    = ST_FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_next_c;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      opcode_q   <= '0;
      operand_q  <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign opcode       = opcode_q;
  assign operand      = operand_q;
  assign enable_count = enable_count_c;
  assign instr_valid  = (state_q == ST_DISPATCH);
  assign pc           = pc_cur;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: memory and microsequencer responders, a
// transaction-level fetch model checked every cycle, plus directed literals.
module tb_instruction_fetcher;

  logic       clock;
  logic       reset_n;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       enable_count;
  logic [2:0] uaddress;
  logic       instr_valid;
  logic       pc_load;
  logic [7:0] pc_load_value;
  logic       halt;
  logic [7:0] pc;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [256];
  int mem_wait;
  int ack_cnt;

  instruction_fetcher #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .opcode       (opcode),
    .operand      (operand),
    .enable_count (enable_count),
    .uaddress     (uaddress),
    .instr_valid  (instr_valid),
    .pc_load      (pc_load),
    .pc_load_value(pc_load_value),
    .halt         (halt),
    .pc           (pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Memory: acknowledges after mem_wait extra cycles of a held request.
  assign mem_ack   = mem_req && (ack_cnt >= mem_wait);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) ack_cnt <= 0;
    else if (mem_req && !mem_ack) ack_cnt <= ack_cnt + 1;
    else ack_cnt <= 0;
  end

  // Microsequencer: opcode A runs 2,3; opcode 1 is a NOP; others run 4.
  function automatic logic [2:0] start_addr(input logic [3:0] op);
    case (op)
      4'hA: return 3'd2;
      4'h1: return 3'd7;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] step_addr(input logic [2:0] ua);
    return (ua == 3'd2) ? 3'd3 : 3'd7;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) uaddress <= 3'd7;
    else if (enable_count) uaddress <= (uaddress == 3'd7) ? start_addr(opcode) : step_addr(uaddress);
  end

  // Reference: an instruction is either being requested, just arrived,
  // running its microprogram, or the fetcher is waiting to start.
  logic [7:0] m_pc, m_addr;
  logic [3:0] m_op, m_opr;
  logic       m_req, m_arrived, m_running;
  int         m_cnt;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pc <= 8'd0; m_addr <= 8'd0; m_op <= 4'd0; m_opr <= 4'd0;
      m_req <= 1'b0; m_arrived <= 1'b0; m_running <= 1'b0; m_cnt <= 0;
    end else begin
      m_arrived <= 1'b0;
      if (m_req) begin
        if (m_cnt >= mem_wait) begin
          {m_op, m_opr} <= mem[m_addr];
          m_pc      <= m_pc + 8'd1;
          m_req     <= 1'b0;
          m_arrived <= 1'b1;
          m_cnt     <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else if (m_arrived) begin
        m_running <= 1'b1;
      end else if (m_running) begin
        if (pc_load) m_pc <= pc_load_value;
        if (uaddress == 3'd7) begin
          m_running <= 1'b0;
          if (!halt) begin
            m_req  <= 1'b1;
            m_addr <= pc_load ? pc_load_value : m_pc;
          end
        end
      end else if (!halt) begin
        m_req  <= 1'b1;
        m_addr <= m_pc;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      check("cyc_mem_req", 32'(mem_req), 32'(m_req));
      check("cyc_mem_addr", 32'(mem_addr), 32'(m_addr));
      check("cyc_opcode", 32'(opcode), 32'(m_op));
      check("cyc_operand", 32'(operand), 32'(m_opr));
      check("cyc_pc", 32'(pc), 32'(m_pc));
      check("cyc_instr_valid", 32'(instr_valid), 32'(m_arrived));
      check("cyc_enable_count", 32'(enable_count),
            32'(m_arrived || (m_running && uaddress != 3'd7)));
    end
  end

  // Waits (bounded) at falling edges: which=0 for mem_req, 1 for instr_valid.
  task automatic wait_sig(input int which, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if ((which == 0 && mem_req === 1'b1) || (which == 1 && instr_valid === 1'b1)) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!seen) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    int en_cnt;
    reset_n = 1'b0; halt = 1'b0; pc_load = 1'b0; pc_load_value = 8'h00; mem_wait = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
    mem[8'h00] = 8'hA5; mem[8'h01] = 8'h13; mem[8'h02] = 8'hA7;
    mem[8'h40] = 8'hA1; mem[8'h41] = 8'h42; mem[8'hFF] = 8'hA9;

    repeat (2) @(negedge clock);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_operand", 32'(operand), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_enable_count", 32'(enable_count), 32'd0);
    reset_n = 1'b1;

    // Zero-wait fetch of A5 at address 0.
    @(negedge clock);
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", 32'(mem_addr), 32'd0);
    @(negedge clock);
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_opcode", 32'(opcode), 32'hA);
    check("first_operand", 32'(operand), 32'h5);
    check("first_pc", 32'(pc), 32'd1);
    mem_wait = 3;

    // enable_count: dispatch plus microaddresses 2 and 3.
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) break;
      en_cnt += 32'(enable_count);
      @(negedge clock);
    end
    check("en_count_a", 32'(en_cnt), 32'd3);

    // Three wait states: request held four cycles.
    for (int i = 0; i < 4; i++) begin
      check("wait_req", 32'(mem_req), 32'd1);
      check("wait_addr", 32'(mem_addr), 32'd1);
      check("wait_no_valid", 32'(instr_valid), 32'd0);
      @(negedge clock);
    end
    check("wait_valid", 32'(instr_valid), 32'd1);
    check("nop_opcode", 32'(opcode), 32'h1);
    check("nop_operand", 32'(operand), 32'h3);
    mem_wait = 0;
    @(negedge clock);
    check("nop_en", 32'(enable_count), 32'd0);
    wait_sig(0, "to_req2");
    check("addr2", 32'(mem_addr), 32'd2);

    // Branch to 0x40 during execute; same pulse during fetch is ignored.
    wait_sig(1, "to_valid2");
    mem_wait = 2;
    @(negedge clock);
    pc_load = 1'b1; pc_load_value = 8'h40;
    @(negedge clock);
    pc_load = 1'b0;
    check("branch_pc", 32'(pc), 32'h40);
    wait_sig(0, "to_req40");
    check("branch_addr", 32'(mem_addr), 32'h40);
    pc_load = 1'b1; pc_load_value = 8'h80;
    @(negedge clock);
    pc_load = 1'b0;
    check("fetch_load_ignored", 32'(pc), 32'h40);
    wait_sig(1, "to_valid40");
    check("pc_after_40", 32'(pc), 32'h41);
    check("opcode_40", 32'(opcode), 32'hA);
    mem_wait = 0;
    wait_sig(0, "to_req41");
    check("addr41", 32'(mem_addr), 32'h41);

    // Branch to 0xFF, then the increment wraps to 0.
    wait_sig(1, "to_valid41");
    @(negedge clock);
    pc_load = 1'b1; pc_load_value = 8'hFF;
    @(negedge clock);
    pc_load = 1'b0;
    wait_sig(0, "to_reqff");
    check("addr_ff", 32'(mem_addr), 32'hFF);
    wait_sig(1, "to_validff");
    check("pc_wrap", 32'(pc), 32'h00);
    check("operand_ff", 32'(operand), 32'h9);

    // Halt mid-execute: instruction completes, then no requests.
    @(negedge clock);
    halt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("halt_no_req", 32'(mem_req), 32'd0);
    end
    halt = 1'b0;
    wait_sig(0, "to_req_resume");
    check("resume_addr", 32'(mem_addr), 32'd0);
    wait_sig(1, "to_valid_resume");
    check("resume_pc", 32'(pc), 32'd1);

    // Reset while a slow fetch is outstanding.
    mem_wait = 10;
    wait_sig(0, "to_req_slow");
    check("slow_addr", 32'(mem_addr), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_mem_req", 32'(mem_req), 32'd0);
    check("async_pc", 32'(pc), 32'd0);
    check("async_opcode", 32'(opcode), 32'd0);
    check("async_enable", 32'(enable_count), 32'd0);
    repeat (2) @(negedge clock);
    mem_wait = 0;
    reset_n = 1'b1;
    wait_sig(1, "to_valid_after_rst");
    check("rst_refetch_opcode", 32'(opcode), 32'hA);
    check("rst_refetch_pc", 32'(pc), 32'd1);
    repeat (5) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
